// File: rtl/am_lock_ctrl.sv
// am_lock_ctrl: alignment-marker lock controller with flywheel.
// Hunts for a valid AM, confirms it over GOOD_AM periods, then holds lock
// until BAD_AM consecutive misses. A free-running flywheel marks the
// expected AM cycle and the FEC frame boundaries.
// Ports:
//   fullclk, rst_n  - clock, async active-low reset
//   isam, am_field  - AM detector strobe and AM index (4..7 invalid)
//   corrupt_am      - forces the AM on an expect cycle to count as a miss
//   err_clr         - synchronous clear of err_cnt
//   am_lock         - high while LOCKED
//   lane_id         - AM index captured in HUNT
//   am_expect       - flywheel expect-cycle marker (combinational)
//   frame_start     - FEC frame boundary pulse (combinational)
//   slip            - one-cycle pulse on each return to HUNT
//   err_cnt         - saturating count of AMs missed while locked
module am_lock_ctrl #(
  parameter int unsigned AM_PERIOD = 42240,
  parameter int unsigned FRAME_LEN = 1320,
  parameter int unsigned GOOD_AM   = 2,
  parameter int unsigned BAD_AM    = 4
) (
  input  logic        fullclk,
  input  logic        rst_n,
  input  logic        isam,
  input  logic [2:0]  am_field,
  input  logic        corrupt_am,
  input  logic        err_clr,
  output logic        am_lock,
  output logic [1:0]  lane_id,
  output logic        am_expect,
  output logic        frame_start,
  output logic        slip,
  output logic [15:0] err_cnt
);

  localparam int unsigned CW = 16;
  localparam int unsigned GW = (GOOD_AM < 2) ? 1 : $clog2(GOOD_AM + 1);
  localparam int unsigned BW = (BAD_AM < 2) ? 1 : $clog2(BAD_AM + 1);

  typedef enum logic [1:0] {HUNT, CONFIRM, LOCKED} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   pcnt, pcnt_nxt;
  logic [CW-1:0]   fcnt, fcnt_nxt;
  logic [GW-1:0]   good_cnt, good_nxt, good_inc;
  logic [BW-1:0]   bad_cnt, bad_nxt, bad_inc;
  logic [1:0]      lane_nxt;
  logic [15:0]     err_nxt;
  logic            slip_nxt;
  logic            reload;
  logic            err_inc;
  logic            am_valid;
  logic            am_good;

  // Expect cycle: flywheel has run a full AM period since the last reload.
  assign am_expect   = (state != HUNT) && (pcnt == CW'(AM_PERIOD));
  assign frame_start = am_lock && (am_expect || (fcnt == CW'(FRAME_LEN)));

  assign am_valid = isam && !am_field[2];
  assign am_good  = am_valid && (am_field[1:0] == lane_id) && !corrupt_am;
  assign good_inc = good_cnt + GW'(1);
  assign bad_inc  = bad_cnt + BW'(1);

  // State register and all registered outputs.
  always_ff @(posedge fullclk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HUNT;
      pcnt     <= CW'(1);
      fcnt     <= CW'(1);
      good_cnt <= '0;
      bad_cnt  <= '0;
      lane_id  <= '0;
      err_cnt  <= '0;
      am_lock  <= 1'b0;
      slip     <= 1'b0;
    end else begin
      state    <= state_nxt;
      pcnt     <= pcnt_nxt;
      fcnt     <= fcnt_nxt;
      good_cnt <= good_nxt;
      bad_cnt  <= bad_nxt;
      lane_id  <= lane_nxt;
      err_cnt  <= err_nxt;
      am_lock  <= (state_nxt == LOCKED);
      slip     <= slip_nxt;
    end
  end

  // Next-state, counters and error accounting.
  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    bad_nxt   = bad_cnt;
    lane_nxt  = lane_id;
    slip_nxt  = 1'b0;
    reload    = 1'b0;
    err_inc   = 1'b0;
    pcnt_nxt  = pcnt;
    fcnt_nxt  = fcnt;

    unique case (state)
      HUNT: begin
        if (am_valid) begin
          lane_nxt  = am_field[1:0];
          good_nxt  = GW'(1);
          bad_nxt   = '0;
          reload    = 1'b1;
          state_nxt = (GOOD_AM <= 1) ? LOCKED : CONFIRM;
        end
      end
      CONFIRM: begin
        if (am_expect) begin
          reload = 1'b1;
          if (am_good) begin
            good_nxt = good_inc;
            if (good_inc >= GW'(GOOD_AM)) begin
              state_nxt = LOCKED;
              bad_nxt   = '0;
            end
          end else begin
            state_nxt = HUNT;
            good_nxt  = '0;
            slip_nxt  = 1'b1;
          end
        end
      end
      LOCKED: begin
        if (am_expect) begin
          reload = 1'b1;
          if (am_good) begin
            bad_nxt = '0;
          end else begin
            err_inc = 1'b1;
            if (bad_inc >= BW'(BAD_AM)) begin
              state_nxt = HUNT;
              bad_nxt   = '0;
              good_nxt  = '0;
              slip_nxt  = 1'b1;
            end else begin
              bad_nxt = bad_inc;
            end
          end
        end
      end
      default: begin
        state_nxt = HUNT;
      end
    endcase

    // Flywheel: reload after capture/expect, free-run outside HUNT, hold in HUNT.
    if (reload) begin
      pcnt_nxt = CW'(1);
      fcnt_nxt = CW'(1);
    end else if (state != HUNT) begin
      pcnt_nxt = pcnt + CW'(1);
      fcnt_nxt = (fcnt == CW'(FRAME_LEN)) ? CW'(1) : fcnt + CW'(1);
    end

    // Clear wins over a coincident miss; count saturates.
    if (err_clr) begin
      err_nxt = '0;
    end else if (err_inc && (err_cnt != 16'hFFFF)) begin
      err_nxt = err_cnt + 16'd1;
    end else begin
      err_nxt = err_cnt;
    end
  end

endmodule

// File: tb/tb_am_lock_ctrl.sv
// Directed bench for am_lock_ctrl: one instance at AM_PERIOD=40/FRAME_LEN=10,
// plus a one-cycle-period instance used to drive err_cnt to saturation.
module tb_am_lock_ctrl;

  logic        fullclk;
  logic        rst_n;
  logic        isam, corrupt_am, err_clr;
  logic [2:0]  am_field;
  logic        am_lock, am_expect, frame_start, slip;
  logic [1:0]  lane_id;
  logic [15:0] err_cnt;

  logic        isam2, corrupt2, errclr2;
  logic [2:0]  field2;
  logic        lock2, expect2, fs2, slip2;
  logic [1:0]  lane2;
  logic [15:0] err2;

  int checks;
  int failures;

  am_lock_ctrl #(.AM_PERIOD(40), .FRAME_LEN(10), .GOOD_AM(2), .BAD_AM(4)) u_dut (
    .fullclk(fullclk), .rst_n(rst_n), .isam(isam), .am_field(am_field),
    .corrupt_am(corrupt_am), .err_clr(err_clr), .am_lock(am_lock),
    .lane_id(lane_id), .am_expect(am_expect), .frame_start(frame_start),
    .slip(slip), .err_cnt(err_cnt)
  );

  am_lock_ctrl #(.AM_PERIOD(1), .FRAME_LEN(1), .GOOD_AM(1), .BAD_AM(70000)) u_sat (
    .fullclk(fullclk), .rst_n(rst_n), .isam(isam2), .am_field(field2),
    .corrupt_am(corrupt2), .err_clr(errclr2), .am_lock(lock2),
    .lane_id(lane2), .am_expect(expect2), .frame_start(fs2),
    .slip(slip2), .err_cnt(err2)
  );

  initial fullclk = 1'b0;
  always #5 fullclk = ~fullclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge fullclk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Advance 'pre' cycles onto an expect cycle, present one AM, then move past it.
  task automatic am_cycle(input int pre, input logic i, input logic [2:0] f, input logic c);
    steps(pre);
    chk("expect_cycle", 32'(am_expect), 32'd1);
    isam = i; am_field = f; corrupt_am = c;
    step();
    isam = 1'b0; am_field = 3'd0; corrupt_am = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; isam = 1'b0; am_field = 3'd0; corrupt_am = 1'b0; err_clr = 1'b0;
    isam2 = 1'b0; field2 = 3'd0; corrupt2 = 1'b0; errclr2 = 1'b0;

    // Reset values
    #2;
    chk("rst_lock", 32'(am_lock), 0);
    chk("rst_lane", 32'(lane_id), 0);
    chk("rst_expect", 32'(am_expect), 0);
    chk("rst_fs", 32'(frame_start), 0);
    chk("rst_slip", 32'(slip), 0);
    chk("rst_err", 32'(err_cnt), 0);
    #20 rst_n = 1'b1;
    step();

    // Lock on lane 2: capture at c, good AM at c+40, lock from c+41
    isam = 1'b1; am_field = 3'd2;
    step();
    isam = 1'b0; am_field = 3'd0;
    chk("cap_lane", 32'(lane_id), 2);
    chk("cap_lock", 32'(am_lock), 0);
    steps(38);
    chk("c39_expect", 32'(am_expect), 0);
    step();
    chk("c40_expect", 32'(am_expect), 1);
    chk("c40_lock", 32'(am_lock), 0);
    isam = 1'b1; am_field = 3'd2;
    step();
    isam = 1'b0; am_field = 3'd0;
    chk("c41_lock", 32'(am_lock), 1);
    for (int i = 41; i <= 80; i++) begin
      if (i > 41) step();
      chk($sformatf("fs_c%0d", i), 32'(frame_start), 32'((i % 10) == 0));
    end
    chk("c80_expect", 32'(am_expect), 1);
    isam = 1'b1; am_field = 3'd2;
    step();
    isam = 1'b0; am_field = 3'd0;
    chk("locked_err0", 32'(err_cnt), 0);

    // Unlock: 3 misses, 1 good, 4 misses
    for (int m = 1; m <= 3; m++) begin
      am_cycle(39, 1'b0, 3'd0, 1'b0);
      chk($sformatf("miss%0d_err", m), 32'(err_cnt), 32'(m));
      chk($sformatf("miss%0d_lock", m), 32'(am_lock), 1);
      chk($sformatf("miss%0d_slip", m), 32'(slip), 0);
    end
    am_cycle(39, 1'b1, 3'd2, 1'b0);
    chk("good_err", 32'(err_cnt), 3);
    chk("good_lock", 32'(am_lock), 1);
    for (int m = 4; m <= 6; m++) begin
      am_cycle(39, 1'b0, 3'd0, 1'b0);
      chk($sformatf("miss%0d_err", m), 32'(err_cnt), 32'(m));
      chk($sformatf("miss%0d_lock", m), 32'(am_lock), 1);
      chk($sformatf("miss%0d_slip", m), 32'(slip), 0);
    end
    am_cycle(39, 1'b0, 3'd0, 1'b0);
    chk("unlock_err", 32'(err_cnt), 7);
    chk("unlock_lock", 32'(am_lock), 0);
    chk("unlock_slip", 32'(slip), 1);
    step();
    chk("unlock_slip_end", 32'(slip), 0);

    // HUNT holds flywheel: no expect/frame_start
    for (int k = 0; k < 50; k++) begin
      step();
      chk("hunt_idle", 32'({am_expect, frame_start}), 0);
    end

    // Confirm fail
    isam = 1'b1; am_field = 3'd0;
    step();
    isam = 1'b0;
    chk("cf_lock", 32'(am_lock), 0);
    am_cycle(39, 1'b0, 3'd0, 1'b0);
    chk("cf_slip", 32'(slip), 1);
    chk("cf_lock2", 32'(am_lock), 0);
    chk("cf_err", 32'(err_cnt), 7);
    step();
    chk("cf_slip_end", 32'(slip), 0);

    // Invalid index ignored in HUNT
    isam = 1'b1; am_field = 3'd6;
    step();
    isam = 1'b0; am_field = 3'd0;
    steps(45);
    chk("inv_expect", 32'(am_expect), 0);
    chk("inv_lock", 32'(am_lock), 0);

    // Lock lane 1, stray AM, wrong index, corrupt
    isam = 1'b1; am_field = 3'd1;
    step();
    isam = 1'b0; am_field = 3'd0;
    am_cycle(39, 1'b1, 3'd1, 1'b0);
    chk("l1_lock", 32'(am_lock), 1);
    chk("l1_lane", 32'(lane_id), 1);
    steps(19);
    isam = 1'b1; am_field = 3'd1;
    step();
    isam = 1'b0; am_field = 3'd0;
    chk("stray_err", 32'(err_cnt), 7);
    am_cycle(19, 1'b1, 3'd3, 1'b0);
    chk("wrong_idx_err", 32'(err_cnt), 8);
    chk("wrong_idx_lock", 32'(am_lock), 1);
    am_cycle(39, 1'b1, 3'd1, 1'b1);
    chk("corrupt_err", 32'(err_cnt), 9);
    am_cycle(39, 1'b1, 3'd1, 1'b0);
    chk("l1_good_err", 32'(err_cnt), 9);
    chk("l1_lane2", 32'(lane_id), 1);

    // Async reset mid-lock
    steps(15);
    chk("pre_rst_lock", 32'(am_lock), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_lock", 32'(am_lock), 0);
    chk("arst_slip", 32'(slip), 0);
    chk("arst_err", 32'(err_cnt), 0);
    chk("arst_lane", 32'(lane_id), 0);
    chk("arst_expect", 32'(am_expect), 0);
    chk("arst_fs", 32'(frame_start), 0);
    #1 rst_n = 1'b1;
    step();
    isam = 1'b1; am_field = 3'd3;
    step();
    isam = 1'b0; am_field = 3'd0;
    chk("relock1_lock", 32'(am_lock), 0);
    am_cycle(39, 1'b1, 3'd3, 1'b0);
    chk("relock2_lock", 32'(am_lock), 1);
    chk("relock_lane", 32'(lane_id), 3);

    // Saturation on the one-cycle-period instance (every cycle an expect)
    isam2 = 1'b1; field2 = 3'd1;
    step();
    isam2 = 1'b0; field2 = 3'd0;
    chk("sat_lock", 32'(lock2), 1);
    chk("sat_lane", 32'(lane2), 1);
    chk("sat_expect", 32'(expect2), 1);
    chk("sat_fs", 32'(fs2), 1);
    chk("sat_err0", 32'(err2), 0);
    steps(65534);
    chk("sat_fffe", 32'(err2), 32'hFFFE);
    step();
    chk("sat_ffff", 32'(err2), 32'hFFFF);
    step();
    chk("sat_hold", 32'(err2), 32'hFFFF);
    chk("sat_lock2", 32'(lock2), 1);
    errclr2 = 1'b1;
    step();
    errclr2 = 1'b0;
    chk("sat_clr", 32'(err2), 0);
    step();
    chk("sat_after_clr", 32'(err2), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
